// File: rtl/half_sequencer.sv
// half_sequencer: splits each 2*NBITS-bit input word into two output beats for the
// downstream half-select mux. Each word is taken with one valid/ready handshake. Both
// halves are registered onto msb_out/lsb_out. dec then selects which half the mux emits
// on each beat. The default beat order is lsb first, then msb; MSB_FIRST=1 reverses it.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset_n   synchronous reset, active low
//   in_data   input word; [2N-1:N] goes to msb_out, [N-1:0] goes to lsb_out
//   in_valid  in_data is valid
//   in_ready  a word can be accepted this cycle (combinational)
//   msb_out   registered high half
//   lsb_out   registered low half
//   dec       registered half select for the mux (1 selects msb)
//   out_valid the current beat is valid
//   out_ready downstream consumes the current beat
//   last      the current beat is the second half of the word
module half_sequencer #(
  parameter int unsigned NBITS     = 7,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2*NBITS-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NBITS-1:0]   msb_out,
  output logic [NBITS-1:0]   lsb_out,
  output logic               dec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               last
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StFirst  = 2'b01,
    StSecond = 2'b10
  } state_e;

  state_e           state_q;
  logic [NBITS-1:0] msb_q;
  logic [NBITS-1:0] lsb_q;
  logic             dec_q;
  logic             out_valid_q;
  logic             last_q;
  logic             accept;

  // A new word can load while the second beat of the previous word is consumed.
  // This is what allows back-to-back words with no bubble.
  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        StIdle:   in_ready = 1'b1;
        StSecond: in_ready = out_ready;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      msb_q       <= '0;
      lsb_q       <= '0;
      dec_q       <= MSB_FIRST;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      // Covers both accept from IDLE and the no-gap reload in SECOND.
      msb_q       <= in_data[2*NBITS-1:NBITS];
      lsb_q       <= in_data[NBITS-1:0];
      dec_q       <= MSB_FIRST;
      last_q      <= 1'b0;
      out_valid_q <= 1'b1;
      state_q     <= StFirst;
    end else begin
      case (state_q)
        StIdle: ;
        StFirst: begin
          if (out_ready) begin
            dec_q   <= ~dec_q;
            last_q  <= 1'b1;
            state_q <= StSecond;
          end
        end
        StSecond: begin
          // With out_ready high, accept could only be low here because in_valid was low.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            dec_q       <= MSB_FIRST;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          dec_q       <= MSB_FIRST;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign msb_out   = msb_q;
  assign lsb_out   = lsb_q;
  assign dec       = dec_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;

endmodule

// File: tb/tb_half_sequencer.sv
module tb_half_sequencer;

  localparam int unsigned NBITS = 7;

  logic             clk;
  logic             reset_n;
  logic [13:0]      in_data;
  logic             out_ready;

  // Instance a uses the default lsb-first order; instance b uses MSB_FIRST=1.
  logic             in_valid_a, in_ready_a, dec_a, out_valid_a, last_a;
  logic [NBITS-1:0] msb_a, lsb_a, mux_a;
  logic             in_valid_b, in_ready_b, dec_b, out_valid_b, last_b;
  logic [NBITS-1:0] msb_b, lsb_b, mux_b;

  int checks;
  int failures;

  half_sequencer #(.NBITS(NBITS), .MSB_FIRST(1'b0)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .msb_out   (msb_a),
    .lsb_out   (lsb_a),
    .dec       (dec_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .last      (last_a)
  );

  half_sequencer #(.NBITS(NBITS), .MSB_FIRST(1'b1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .msb_out   (msb_b),
    .lsb_out   (lsb_b),
    .dec       (dec_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .last      (last_b)
  );

  // Model of the downstream half-select mux.
  assign mux_a = dec_a ? msb_a : lsb_a;
  assign mux_b = dec_b ? msb_b : lsb_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    in_data    = 14'h1234;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    out_ready  = 1'b1;

    // 1: reset held for two cycles with in_valid high.
    step();
    step();
    check("rst_out_valid", 16'(out_valid_a), 16'h0);
    check("rst_msb", 16'(msb_a), 16'h0);
    check("rst_lsb", 16'(lsb_a), 16'h0);
    check("rst_dec", 16'(dec_a), 16'h0);
    check("rst_last", 16'(last_a), 16'h0);
    check("rst_in_ready", 16'(in_ready_a), 16'h0);
    check("rst_dec_b", 16'(dec_b), 16'h1);
    reset_n    = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    #1;
    check("rel_in_ready", 16'(in_ready_a), 16'h1);

    // 2: single word.
    in_data    = 14'h2A55;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    in_data    = 14'h0000;
    #1;
    check("s_valid1", 16'(out_valid_a), 16'h1);
    check("s_dec1", 16'(dec_a), 16'h0);
    check("s_last1", 16'(last_a), 16'h0);
    check("s_mux1", 16'(mux_a), 16'h55);
    check("s_in_ready_first", 16'(in_ready_a), 16'h0);
    step();
    check("s_valid2", 16'(out_valid_a), 16'h1);
    check("s_dec2", 16'(dec_a), 16'h1);
    check("s_last2", 16'(last_a), 16'h1);
    check("s_mux2", 16'(mux_a), 16'h54);
    check("s_in_ready_second", 16'(in_ready_a), 16'h1);
    step();
    check("s_idle_valid", 16'(out_valid_a), 16'h0);
    check("s_idle_last", 16'(last_a), 16'h0);
    check("s_idle_dec", 16'(dec_a), 16'h0);
    check("s_idle_msb_hold", 16'(msb_a), 16'h54);
    check("s_idle_lsb_hold", 16'(lsb_a), 16'h55);

    // 3: back-to-back words with in_valid held.
    in_data    = 14'h2A55;
    in_valid_a = 1'b1;
    step();
    in_data = 14'h3F80;
    #1;
    check("b_mux1", 16'(mux_a), 16'h55);
    check("b_in_ready1", 16'(in_ready_a), 16'h0);
    step();
    check("b_mux2", 16'(mux_a), 16'h54);
    check("b_last2", 16'(last_a), 16'h1);
    check("b_in_ready2", 16'(in_ready_a), 16'h1);
    step();
    in_valid_a = 1'b0;
    #1;
    check("b_valid3", 16'(out_valid_a), 16'h1);
    check("b_mux3", 16'(mux_a), 16'h00);
    check("b_last3", 16'(last_a), 16'h0);
    check("b_in_ready3", 16'(in_ready_a), 16'h0);
    step();
    check("b_mux4", 16'(mux_a), 16'h7F);
    check("b_last4", 16'(last_a), 16'h1);
    step();
    check("b_idle", 16'(out_valid_a), 16'h0);

    // 4: stall in FIRST while in_data toggles.
    in_data    = 14'h2A55;
    in_valid_a = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = (i % 2 == 0) ? 14'h15AA : 14'h3FFF;
      #1;
      check("st_dec", 16'(dec_a), 16'h0);
      check("st_valid", 16'(out_valid_a), 16'h1);
      check("st_msb", 16'(msb_a), 16'h54);
      check("st_lsb", 16'(lsb_a), 16'h55);
      check("st_in_ready", 16'(in_ready_a), 16'h0);
      step();
    end
    check("st_held_mux", 16'(mux_a), 16'h55);
    out_ready  = 1'b1;
    in_valid_a = 1'b0;
    step();
    check("st_resume_mux", 16'(mux_a), 16'h54);
    check("st_resume_last", 16'(last_a), 16'h1);
    step();
    check("st_idle", 16'(out_valid_a), 16'h0);

    // 5: MSB_FIRST ordering.
    in_data    = 14'h2A55;
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    #1;
    check("m_dec1", 16'(dec_b), 16'h1);
    check("m_mux1", 16'(mux_b), 16'h54);
    check("m_last1", 16'(last_b), 16'h0);
    check("m_valid1", 16'(out_valid_b), 16'h1);
    step();
    check("m_dec2", 16'(dec_b), 16'h0);
    check("m_mux2", 16'(mux_b), 16'h55);
    check("m_last2", 16'(last_b), 16'h1);
    step();
    check("m_idle_valid", 16'(out_valid_b), 16'h0);
    check("m_idle_dec", 16'(dec_b), 16'h1);

    // 6: reset during SECOND drops the word.
    in_data    = 14'h3F80;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    step();
    check("r_in_second_last", 16'(last_a), 16'h1);
    reset_n = 1'b0;
    #1;
    check("r_in_ready_low", 16'(in_ready_a), 16'h0);
    step();
    check("r_valid", 16'(out_valid_a), 16'h0);
    check("r_last", 16'(last_a), 16'h0);
    check("r_dec", 16'(dec_a), 16'h0);
    reset_n = 1'b1;
    #1;
    check("r_in_ready_rel", 16'(in_ready_a), 16'h1);
    step();
    check("r_idle_valid", 16'(out_valid_a), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
